card_deal_arbiter: RTL and testbench
====================================

// Module: card_deal_arbiter
// PURPOSE
//  Shares one 52-card deck between NUM_REQ requesters (player/dealer hand FSMs) and
//  deals one unique card per granted request. Draws a card index from an external
//  random word, resolves collisions by probing for the next free slot one slot per
//  cycle, and tracks the used mask and remaining count. It also sequences a new round
//  by clearing the deck.
// PARAMETERS
//  NUM_REQ    4   number of requesters
//  DECK_SIZE  52  cards per deck; indices 0..DECK_SIZE-1
//  CARD_W     6   card index / count width
//  RND_W      16  random word width
// PORTS
//  clk         in   1        system clock; all state on rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  new_round   in   1        1-cycle pulse: clear deck, abort any draw in flight
//  rnd         in   RND_W    free-running random word, sampled only on accept
//  req         in   NUM_REQ  per-requester card request, held until its gnt pulse
//  gnt         out  NUM_REQ  one-hot 1-cycle grant, coincident with card_valid
//  card        out  CARD_W   dealt card index, valid while card_valid=1
//  card_valid  out  1        1-cycle pulse: card holds a fresh unique index
//  cards_left  out  CARD_W   undealt cards remaining
//  deck_empty  out  1        cards_left==0, registered
//  busy        out  1        FSM not in IDLE
// BEHAVIOUR
//  - Reset: gnt=0, card=0, card_valid=0, busy=0, deck_empty=0, cards_left=DECK_SIZE,
//    used mask=0, RR pointer selects req[0] as highest priority, FSM=IDLE.
//  - FSM states: IDLE, CLEAR, BURN (CARD_BURN_EN only), PROBE.
//  - IDLE: new_round has priority -> CLEAR. Else if |req && !deck_empty: pick the
//    round-robin winner (first set bit after the last granted index, with wrap),
//    latch winner and idx = rnd % DECK_SIZE (full RND_W-bit modulo) -> PROBE.
//  - PROBE: if used[idx]==0, set used[idx], card<=idx, gnt<=onehot(winner),
//    card_valid<=1, cards_left-=1, move the RR pointer to winner -> IDLE. Else
//    idx <= (idx==DECK_SIZE-1) ? 0 : idx+1 and stay in PROBE. The probe is bounded
//    to DECK_SIZE cycles because a non-empty deck is required on accept.
//  - Latency: gnt/card_valid asserts on the edge after the first PROBE cycle, which
//    is 2 cycles after req is seen in IDLE. Each occupied slot probed adds 1 cycle.
//  - gnt and card_valid are high for exactly 1 cycle. card holds its value until the
//    next deal. A requester with req=1 after its gnt is a new request.
//  - CLEAR: used=0, cards_left=DECK_SIZE, deck_empty=0, RR pointer unchanged -> IDLE.
//  - new_round in PROBE: abort with no gnt; go to CLEAR next cycle.
//  - new_round on the same edge a gnt would fire: the abort wins and no gnt is issued.
//  - deck_empty=1: requests are left pending and no gnt is issued until new_round.
//  - rst_n asserted mid-probe: immediate return to reset values, no gnt.
// CONFIGURATION
//  CARD_BURN_EN defined: CLEAR goes to BURN, which samples rnd % DECK_SIZE, probes
//    like PROBE and marks that card used with no gnt/card_valid. cards_left ends at
//    DECK_SIZE-1, then the FSM returns to IDLE. busy stays high throughout.
//  CARD_BURN_EN undefined: the BURN state is not compiled and CLEAR goes to IDLE.
// STRUCTURE
//  - Package card_pkg: DECK_SIZE, CARD_W, RND_W localparams, FSM state enum, and the
//    wrap-increment function for the card index.
//  - Sub-module rr_arbiter (NUM_REQ): combinational winner from req and the last
//    grant pointer. The pointer register lives in card_deal_arbiter.
// TESTING
//  1. Reset, req=0001, rnd=5 -> 2 cycles later gnt=0001, card=5, card_valid pulse,
//     cards_left=51.
//  2. Then req=0010, rnd=57 (57%52=5, occupied) -> 1 extra cycle, gnt=0010, card=6,
//     cards_left=50.
//  3. Wrap: with card 51 used, req=0001, rnd=51 -> card=0 after 1 probe step.
//  4. req=1111 held after a grant to index 0 -> successive grants in the order
//     0010, 0100, 1000, 0001, all 4 cards distinct.
//  5. 52 grants -> deck_empty=1, cards_left=0; a further req gets no gnt for 10
//     cycles; new_round -> cards_left=52, then the pending req is granted.
//  6. Force a long probe (mask mostly full), pulse new_round mid-PROBE -> no gnt,
//     cards_left=52. With CARD_BURN_EN: cards_left=51 and busy drops afterwards.

Source files
------------

// File: rtl/card_pkg.sv
// card_pkg: deck geometry, FSM state encoding and card-index wrap helper.
// The BURN state exists only when CARD_BURN_EN is defined.
package card_pkg;
    localparam int DECK_SIZE = 52;
    localparam int CARD_W    = 6;
    localparam int RND_W     = 16;

`ifdef CARD_BURN_EN
    typedef enum logic [1:0] {IDLE, CLEAR, PROBE, BURN} state_e;
`else
    typedef enum logic [1:0] {IDLE, CLEAR, PROBE} state_e;
`endif

    function automatic logic [CARD_W-1:0] wrap_inc(input logic [CARD_W-1:0] i);
        return (i == CARD_W'(DECK_SIZE - 1)) ? '0 : i + 1'b1;
    endfunction
endpackage

// File: rtl/card_deal_arbiter_rr.sv
// rr_arbiter: combinational round-robin winner, first set request after ptr_i with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [PW-1:0]      win_o,
    output logic               valid_o
);
    // Scan from farthest to nearest so the nearest request after ptr_i wins.
    always_comb begin
        win_o   = '0;
        valid_o = |req_i;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req_i[(int'(ptr_i) + k) % NUM_REQ]) win_o = PW'((int'(ptr_i) + k) % NUM_REQ);
    end
endmodule

// File: rtl/card_deal_arbiter.sv
// card_deal_arbiter: deals unique cards from a shared deck to round-robin requesters.
// Define CARD_BURN_EN to burn one random card after every deck clear.
module card_deal_arbiter
    import card_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_round_i,
    input  logic [RND_W-1:0]   rnd_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [CARD_W-1:0]  card_o,
    output logic               card_valid_o,
    output logic [CARD_W-1:0]  cards_left_o,
    output logic               deck_empty_o,
    output logic               busy_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e               state_q, state_d;
    logic [CARD_W-1:0]    idx_q, idx_d, card_q, card_d, left_q, left_d, rnd_mod;
    logic [PW-1:0]        win_q, win_d, ptr_q, ptr_d, arb_win;
    logic                 arb_valid, empty_q, empty_d, valid_q, valid_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [DECK_SIZE-1:0] used_q, used_d;

    assign rnd_mod = CARD_W'(rnd_i % RND_W'(DECK_SIZE));

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .win_o   (arb_win),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        used_d  = used_q;
        left_d  = left_q;
        empty_d = empty_q;
        card_d  = card_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (new_round_i) state_d = CLEAR;
                else if (arb_valid && !empty_q) begin
                    win_d   = arb_win;
                    idx_d   = rnd_mod;
                    state_d = PROBE;
                end
            end
            CLEAR: begin
                used_d  = '0;
                left_d  = CARD_W'(DECK_SIZE);
                empty_d = 1'b0;
`ifdef CARD_BURN_EN
                idx_d   = rnd_mod;
                state_d = BURN;
`else
                state_d = IDLE;
`endif
            end
            PROBE: begin
                if (new_round_i) state_d = CLEAR;
                else if (used_q[idx_q]) idx_d = wrap_inc(idx_q);
                else begin
                    used_d[idx_q] = 1'b1;
                    left_d        = left_q - 1'b1;
                    empty_d       = (left_q == CARD_W'(1));
                    card_d        = idx_q;
                    gnt_d[win_q]  = 1'b1;
                    valid_d       = 1'b1;
                    ptr_d         = win_q;
                    state_d       = IDLE;
                end
            end
`ifdef CARD_BURN_EN
            // Same probe walk as PROBE, but the card is discarded silently.
            BURN: begin
                if (new_round_i) state_d = CLEAR;
                else if (used_q[idx_q]) idx_d = wrap_inc(idx_q);
                else begin
                    used_d[idx_q] = 1'b1;
                    left_d        = left_q - 1'b1;
                    state_d       = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            win_q   <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
            used_q  <= '0;
            left_q  <= CARD_W'(DECK_SIZE);
            empty_q <= 1'b0;
            card_q  <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            used_q  <= used_d;
            left_q  <= left_d;
            empty_q <= empty_d;
            card_q  <= card_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign card_o       = card_q;
    assign card_valid_o = valid_q;
    assign cards_left_o = left_q;
    assign deck_empty_o = empty_q;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_card_deal_arbiter.sv
// tb_card_deal_arbiter: vector table, random deals against a deck model, abort/reset corners.
module tb_card_deal_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, new_round;
    logic [15:0] rnd;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [5:0]  card, cards_left;
    logic        card_valid, deck_empty, busy;
    int          checks = 0, errors = 0;
    bit          churn = 0;
    bit          used_m[52];
    int          left_m, last_m;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] rnd;
        int          win;
        int          card;
        int          lat;
        int          left;
    } vec_t;
    vec_t tbl[8];

    card_deal_arbiter #(.NUM_REQ(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_round_i  (new_round),
        .rnd_i        (rnd),
        .req_i        (req),
        .gnt_o        (gnt),
        .card_o       (card),
        .card_valid_o (card_valid),
        .cards_left_o (cards_left),
        .deck_empty_o (deck_empty),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic int first_free(input int s);
        for (int k = 0; k < 52; k++) if (!used_m[(s + k) % 52]) return (s + k) % 52;
        return -1;
    endfunction

    function automatic int rr_win(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) if (r[(last_m + k) % 4]) return (last_m + k) % 4;
        return -1;
    endfunction

    task automatic model_clear(input int w, input bit burn);
        for (int i = 0; i < 52; i++) used_m[i] = 0;
        left_m = 52;
        if (burn) begin
            used_m[first_free(w % 52)] = 1;
            left_m = 51;
        end
    endtask

    task automatic model_take(input int c, input int w);
        used_m[c] = 1;
        left_m--;
        last_m = w;
    endtask

    task automatic wait_gnt(output int cyc, output bit got, output logic v1);
        got = 0; cyc = 0; v1 = 0;
        for (int i = 1; i <= 80 && !got; i++) begin
            @(negedge clk);
            if (i == 1) v1 = card_valid;
            if (gnt != 0) begin
                got = 1;
                cyc = i;
            end else if (churn) begin
                rnd = 16'($urandom);
                if ($urandom_range(0, 3) == 0) req = req | 4'(1 << $urandom_range(0, 3));
            end
        end
    endtask

    task automatic rand_deal();
        int w, win, s, c, cyc;
        bit got;
        logic v1;
        req = req | (4'($urandom) & 4'($urandom));
        if (req == 0) req = 4'(1 << $urandom_range(0, 3));
        w = int'(16'($urandom));
        rnd = 16'(w);
        win = rr_win(req);
        s = w % 52;
        c = first_free(s);
        churn = 1;
        wait_gnt(cyc, got, v1);
        churn = 0;
        chk("rand_timeout", 32'(got), 1);
        chk("rand_gnt", 32'(gnt), 32'(1 << win));
        chk("rand_card", 32'(card), 32'(c));
        chk("rand_latency", 32'(cyc), 32'(2 + (c - s + 52) % 52));
        chk("rand_left", 32'(cards_left), 32'(left_m - 1));
        chk("rand_valid", 32'(card_valid), 1);
        chk("rand_prev_valid_low", 32'(v1), 0);
        model_take(c, win);
        req = req & ~gnt;
    endtask

    bit burn_en;
    initial begin
        int cyc, w, win, c, best_s, best_p, p;
        bit got, ng;
        logic v1;
`ifdef CARD_BURN_EN
        burn_en = 1;
`else
        burn_en = 0;
`endif
        tbl[0] = '{4'b0001, 16'd5,  0, 5,  2, 51};
        tbl[1] = '{4'b0010, 16'd57, 1, 6,  3, 50};
        tbl[2] = '{4'b0001, 16'd51, 0, 51, 2, 49};
        tbl[3] = '{4'b0001, 16'd51, 0, 0,  3, 48};
        tbl[4] = '{4'b1111, 16'd10, 1, 10, 2, 47};
        tbl[5] = '{4'b1111, 16'd20, 2, 20, 2, 46};
        tbl[6] = '{4'b1111, 16'd30, 3, 30, 2, 45};
        tbl[7] = '{4'b1111, 16'd40, 0, 40, 2, 44};

        rst_n = 0; new_round = 0; rnd = 0; req = 0;
        model_clear(0, 0);
        last_m = 3;
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_card", 32'(card), 0);
        chk("rst_valid", 32'(card_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_empty", 32'(deck_empty), 0);
        chk("rst_left", 32'(cards_left), 52);

        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req;
            rnd = tbl[i].rnd;
            wait_gnt(cyc, got, v1);
            chk("vec_gnt", 32'(gnt), 32'(1 << tbl[i].win));
            chk("vec_card", 32'(card), 32'(tbl[i].card));
            chk("vec_latency", 32'(cyc), 32'(tbl[i].lat));
            chk("vec_left", 32'(cards_left), 32'(tbl[i].left));
            chk("vec_valid", 32'(card_valid), 1);
            model_take(tbl[i].card, tbl[i].win);
        end
        req = req & ~gnt;

        while (left_m > 0) rand_deal();
        req = req | 4'b0100;
        chk("empty_flag", 32'(deck_empty), 1);
        chk("empty_left", 32'(cards_left), 0);
        ng = 0;
        repeat (10) begin
            @(negedge clk);
            if (gnt != 0) ng = 1;
        end
        chk("empty_no_gnt", 32'(ng), 0);
        chk("empty_idle", 32'(busy), 0);

        w = int'(16'($urandom));
        rnd = 16'(w);
        new_round = 1;
        @(negedge clk);
        new_round = 0;
        model_clear(w, burn_en);
        win = rr_win(req);
        c = first_free(w % 52);
        wait_gnt(cyc, got, v1);
        chk("refill_gnt", 32'(gnt), 32'(1 << win));
        chk("refill_card", 32'(card), 32'(c));
        chk("refill_left", 32'(cards_left), 32'(left_m - 1));
        chk("refill_empty", 32'(deck_empty), 0);
        model_take(c, win);
        req = req & ~gnt;

        while (left_m > 3) rand_deal();
        best_s = 0; best_p = -1;
        for (int s = 0; s < 52; s++) begin
            p = (first_free(s) - s + 52) % 52;
            if (p > best_p) begin best_p = p; best_s = s; end
        end
        req = 4'b1000;
        rnd = 16'(best_s);
        ng = 0;
        repeat (3) begin
            @(negedge clk);
            if (gnt != 0) ng = 1;
        end
        chk("long_probe_busy", 32'(busy), 1);
        new_round = 1;
        req = 0;
        @(negedge clk);
        new_round = 0;
        repeat (8) begin
            @(negedge clk);
            if (gnt != 0) ng = 1;
        end
        model_clear(best_s, burn_en);
        chk("abort_no_gnt", 32'(ng), 0);
        chk("abort_left", 32'(cards_left), 32'(left_m));
        chk("abort_busy", 32'(busy), 0);
        chk("abort_empty", 32'(deck_empty), 0);

        w = first_free(13);
        req = 4'b0001;
        rnd = 16'(w);
        @(negedge clk);
        new_round = 1;
        req = 0;
        @(negedge clk);
        new_round = 0;
        ng = 0;
        repeat (8) begin
            @(negedge clk);
            if (gnt != 0 || card_valid) ng = 1;
        end
        model_clear(w, burn_en);
        chk("edge_abort_no_gnt", 32'(ng), 0);
        chk("edge_abort_left", 32'(cards_left), 32'(left_m));

        req = 4'b0010;
        rnd = 16'd9;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_card", 32'(card), 0);
        chk("midrst_valid", 32'(card_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_left", 32'(cards_left), 52);
        req = 0;
        @(negedge clk);
        chk("midrst_hold_gnt", 32'(gnt), 0);
        rst_n = 1;
        model_clear(0, 0);
        last_m = 3;
        req = 4'b1111;
        rnd = 16'd7;
        wait_gnt(cyc, got, v1);
        chk("post_rst_gnt", 32'(gnt), 1);
        chk("post_rst_card", 32'(card), 7);
        chk("post_rst_latency", 32'(cyc), 2);
        chk("post_rst_left", 32'(cards_left), 51);
        req = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
